twiddle_gen: RTL and testbench

TWIDDLE_GEN -- requirements
Module: twiddle_gen

---
 rtl/fft_pkg.sv | 49 ++++
 rtl/twiddle_rom_q.sv | 35 +++
 rtl/twiddle_gen.sv | 142 ++++++++++++++
 tb/tb_twiddle_gen.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the FFT twiddle generator.
//   state_e          - twiddle_gen sequencer states
//   quad_e           - quadrant of the exponent e (top two bits of e)
//   log2n()          - transform length -> address width
//   quarter_cos()    - elaboration-time quarter-wave cosine generator
package fft_pkg;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_e;

  function automatic int log2n(input int n);
    return $clog2(n);
  endfunction

  // pi in Q30 fixed point
  localparam longint PI_Q30 = 64'sd3373259426;
  localparam int     FRAC   = 30;

  // round(cos(2*pi*r/n) * (2^(w-1)-1)) for 0 <= r <= n/4, using integer-only
  // Taylor evaluation so the table folds to constants at elaboration.
  // Terms up to x^18 keep the error far below one LSB for x <= pi/2.
  function automatic int quarter_cos(input int r, input int n, input int w);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint amp;
    x    = (2 * PI_Q30 * longint'(r)) / longint'(n);
    x2   = (x * x) >>> FRAC;
    term = longint'(1) <<< FRAC;
    sum  = term;
    for (int unsigned i = 1; i <= 9; i++) begin
      term = -(((term * x2) >>> FRAC) / longint'((2 * i - 1) * (2 * i)));
      sum  = sum + term;
    end
    amp = (longint'(1) <<< (w - 1)) - 1;
    return int'((sum * amp + (longint'(1) <<< (FRAC - 1))) >>> FRAC);
  endfunction

endpackage

// File: rtl/twiddle_rom_q.sv
// twiddle_rom_q: quarter-wave cosine table C[r], r = 0..N/4, two
// combinational read ports so one word needs C[r] and C[N/4-r] together.
//   i_addr_a/i_addr_b : table addresses (out-of-range reads return 0)
//   o_data_a/o_data_b : C[i_addr_a], C[i_addr_b]
module twiddle_rom_q
  import fft_pkg::*;
#(
  parameter  int BIT_WIDTH = 8,
  parameter  int FFT_SIZE  = 16,
  localparam int LOG2N     = log2n(FFT_SIZE),
  localparam int AW        = LOG2N - 1
) (
  input  logic        [AW-1:0]        i_addr_a,
  input  logic        [AW-1:0]        i_addr_b,
  output logic signed [BIT_WIDTH-1:0] o_data_a,
  output logic signed [BIT_WIDTH-1:0] o_data_b
);

  localparam int DEPTH = FFT_SIZE / 4 + 1;

  logic signed [BIT_WIDTH-1:0] w_tab [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_tab
    localparam int CV = quarter_cos(g, FFT_SIZE, BIT_WIDTH);
    assign w_tab[g] = BIT_WIDTH'(CV);
  end

  always_comb begin
    o_data_a = '0;
    o_data_b = '0;
    if (int'(i_addr_a) < DEPTH) o_data_a = w_tab[i_addr_a];
    if (int'(i_addr_b) < DEPTH) o_data_b = w_tab[i_addr_b];
  end

endmodule

// File: rtl/twiddle_gen.sv
// twiddle_gen: streams the N/2 FFT twiddle factors W^e, e = (k << stride)
// mod N, k = 0..N/2-1, as (cos, -sin) pairs over a valid/ready handshake.
//   clk, rst        : clock, asynchronous active-high reset
//   start, stride   : request a sequence (IDLE only), exponent step 2^stride
//   out_ready       : consumer accepts current word
//   out_valid       : word valid; weight_re/weight_im/out_index/out_last
//   busy            : from accepted start until last word accepted
module twiddle_gen
  import fft_pkg::*;
#(
  parameter  int BIT_WIDTH = 8,
  parameter  int FFT_SIZE  = 16,
  localparam int LOG2N     = log2n(FFT_SIZE),
  localparam int SW        = $clog2(LOG2N),
  localparam int KW        = LOG2N - 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic        [SW-1:0]        stride,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic signed [BIT_WIDTH-1:0] weight_re,
  output logic signed [BIT_WIDTH-1:0] weight_im,
  output logic        [KW-1:0]        out_index,
  output logic                        out_last,
  output logic                        busy
);

  localparam logic [KW-1:0] K_LAST = KW'(FFT_SIZE / 2 - 1);
  localparam logic [KW-1:0] QTR    = KW'(FFT_SIZE / 4);

  state_e                      r_state;
  logic        [KW-1:0]        r_k;
  logic        [SW-1:0]        r_stride;
  logic                        r_valid;
  logic                        r_busy;
  logic                        r_last;
  logic signed [BIT_WIDTH-1:0] r_re;
  logic signed [BIT_WIDTH-1:0] r_im;

  logic        [SW-1:0]        w_stride_sat;
  logic        [SW-1:0]        w_stride_sel;
  logic        [KW-1:0]        w_k_next;
  logic        [LOG2N-1:0]     w_e;
  quad_e                       w_quad;
  logic        [KW-1:0]        w_addr_a;
  logic        [KW-1:0]        w_addr_b;
  logic signed [BIT_WIDTH-1:0] w_ca;
  logic signed [BIT_WIDTH-1:0] w_cb;
  logic signed [BIT_WIDTH-1:0] w_re;
  logic signed [BIT_WIDTH-1:0] w_im;
  logic                        w_hs;

  assign w_stride_sat = (int'(stride) >= LOG2N) ? SW'(LOG2N - 1) : stride;

  // The word for the index about to be presented is computed from next-k so
  // it can be registered on the same edge that advances the counter.
  assign w_stride_sel = (r_state == S_IDLE) ? w_stride_sat : r_stride;
  assign w_k_next     = (r_state == S_IDLE) ? '0 : r_k + 1'b1;
  assign w_e          = {1'b0, w_k_next} << w_stride_sel;
  assign w_quad       = quad_e'(w_e[LOG2N-1 -: 2]);
  assign w_addr_a     = {1'b0, w_e[LOG2N-3:0]};
  assign w_addr_b     = QTR - w_addr_a;
  assign w_hs         = r_valid & out_ready;

  twiddle_rom_q #(
    .BIT_WIDTH (BIT_WIDTH),
    .FFT_SIZE  (FFT_SIZE)
  ) u_rom (
    .i_addr_a (w_addr_a),
    .i_addr_b (w_addr_b),
    .o_data_a (w_ca),
    .o_data_b (w_cb)
  );

  // Quadrant fold: C[r] = cos part, C[N/4-r] = sin part within the quadrant.
  always_comb begin
    w_re = '0;
    w_im = '0;
    unique case (w_quad)
      QUAD_0: begin w_re =  w_ca; w_im = -w_cb; end
      QUAD_1: begin w_re = -w_cb; w_im = -w_ca; end
      QUAD_2: begin w_re = -w_ca; w_im =  w_cb; end
      QUAD_3: begin w_re =  w_cb; w_im =  w_ca; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_k      <= '0;
      r_stride <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_last   <= 1'b0;
      r_re     <= '0;
      r_im     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_RUN;
            r_stride <= w_stride_sat;
            r_k      <= '0;
            r_valid  <= 1'b1;
            r_busy   <= 1'b1;
            r_last   <= (K_LAST == '0);
            r_re     <= w_re;
            r_im     <= w_im;
          end
        end
        S_RUN: begin
          if (w_hs) begin
            if (r_last) begin
              r_state <= S_IDLE;
              r_k     <= '0;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_last  <= 1'b0;
              r_re    <= '0;
              r_im    <= '0;
            end else begin
              r_k    <= w_k_next;
              r_last <= (w_k_next == K_LAST);
              r_re   <= w_re;
              r_im   <= w_im;
            end
          end
        end
      endcase
    end
  end

  assign out_valid = r_valid;
  assign busy      = r_busy;
  assign out_last  = r_last;
  assign out_index = r_k;
  assign weight_re = r_re;
  assign weight_im = r_im;

endmodule

// File: tb/tb_twiddle_gen.sv
module tb_twiddle_gen;

  localparam int BW = 8;
  localparam int N  = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic        [1:0]    stride;
  logic                 out_ready;
  logic                 out_valid;
  logic signed [BW-1:0] weight_re;
  logic signed [BW-1:0] weight_im;
  logic        [2:0]    out_index;
  logic                 out_last;
  logic                 busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  twiddle_gen #(
    .BIT_WIDTH (BW),
    .FFT_SIZE  (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stride    (stride),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .weight_re (weight_re),
    .weight_im (weight_im),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy)
  );

  typedef struct {
    int stride;
    int k;
    int re;
    int im;
  } vec_t;

  vec_t vecs[32];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_word(input string tag, input int k, input int re, input int im);
    check({tag, ".valid"}, int'(out_valid), 1);
    check({tag, ".busy"},  int'(busy), 1);
    check({tag, ".index"}, int'(out_index), k);
    check({tag, ".re"},    int'(weight_re), re);
    check({tag, ".im"},    int'(weight_im), im);
    check({tag, ".last"},  int'(out_last), (k == 7) ? 1 : 0);
  endtask

  task automatic chk_idle(input string tag);
    check({tag, ".valid"}, int'(out_valid), 0);
    check({tag, ".busy"},  int'(busy), 0);
    check({tag, ".re"},    int'(weight_re), 0);
    check({tag, ".im"},    int'(weight_im), 0);
    check({tag, ".index"}, int'(out_index), 0);
    check({tag, ".last"},  int'(out_last), 0);
  endtask

  initial begin
    int cnt;
    vecs = '{
      '{0,0, 127,   0}, '{0,1, 117, -49}, '{0,2,  90, -90}, '{0,3,  49,-117},
      '{0,4,   0,-127}, '{0,5, -49,-117}, '{0,6, -90, -90}, '{0,7,-117, -49},
      '{1,0, 127,   0}, '{1,1,  90, -90}, '{1,2,   0,-127}, '{1,3, -90, -90},
      '{1,4,-127,   0}, '{1,5, -90,  90}, '{1,6,   0, 127}, '{1,7,  90,  90},
      '{2,0, 127,   0}, '{2,1,   0,-127}, '{2,2,-127,   0}, '{2,3,   0, 127},
      '{2,4, 127,   0}, '{2,5,   0,-127}, '{2,6,-127,   0}, '{2,7,   0, 127},
      '{3,0, 127,   0}, '{3,1,-127,   0}, '{3,2, 127,   0}, '{3,3,-127,   0},
      '{3,4, 127,   0}, '{3,5,-127,   0}, '{3,6, 127,   0}, '{3,7,-127,   0}
    };

    rst       = 1'b1;
    start     = 1'b0;
    stride    = 2'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("post_reset");

    // Table: full sequences at every stride, out_ready held high.
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (vecs[i].k == 0) begin
        start  = 1'b1;
        stride = 2'(vecs[i].stride);
        @(negedge clk);
        start  = 1'b0;
        stride = 2'(vecs[i].stride + 1);  // must not affect the running sequence
      end
      chk_word($sformatf("s%0d_k%0d", vecs[i].stride, vecs[i].k),
               vecs[i].k, vecs[i].re, vecs[i].im);
      @(negedge clk);
      if (vecs[i].k == 7) chk_idle($sformatf("s%0d_end", vecs[i].stride));
    end

    // Back-pressure at k=2 for three cycles.
    start  = 1'b1;
    stride = 2'd0;
    @(negedge clk);
    start = 1'b0;
    chk_word("bp_k0", 0, 127, 0);
    @(negedge clk);
    chk_word("bp_k1", 1, 117, -49);
    @(negedge clk);
    chk_word("bp_k2", 2, 90, -90);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_word($sformatf("bp_hold%0d", c), 2, 90, -90);
    end
    out_ready = 1'b1;
    for (int k = 3; k < 8; k++) begin
      @(negedge clk);
      chk_word($sformatf("bp_k%0d", k), k, vecs[k].re, vecs[k].im);
    end
    @(negedge clk);
    chk_idle("bp_end");

    // start held high through the whole run, including the final handshake.
    start  = 1'b1;
    stride = 2'd0;
    cnt    = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (cnt < 8) begin
          check($sformatf("spam_idx%0d", cnt), int'(out_index), cnt);
          check($sformatf("spam_re%0d", cnt), int'(weight_re), vecs[cnt].re);
        end
        cnt++;
      end else if (cnt > 0) begin
        break;
      end
    end
    start = 1'b0;
    check("spam_words", cnt, 8);
    chk_idle("spam_end");
    @(negedge clk);
    check("spam_stay_idle", int'(out_valid), 0);

    // Reset in the middle of a run.
    start  = 1'b1;
    stride = 2'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk_word("rst_pre_k2", 2, 90, -90);
    rst = 1'b1;
    #1;
    chk_idle("rst_async");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_no_word", int'(out_valid), 0);
    end
    start  = 1'b1;
    stride = 2'd0;
    @(negedge clk);
    start = 1'b0;
    chk_word("rst_restart_k0", 0, 127, 0);
    @(negedge clk);
    chk_word("rst_restart_k1", 1, 117, -49);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
